// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller owning the PC and the IF/ID
// register, with static predict-taken branches, decode redirects, hazard
// stalls and a halt freeze.
// Optional macro FETCH_PERF_EN adds perf_fetch / perf_miss event counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        miss,
  input  logic [31:0] rpc,
  input  logic        halt,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_miss,
`endif
  output logic        halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] pc4;
  logic [31:0] pred_pc;
  logic        do_fetch;
  logic        do_miss;

  // Static prediction: conditional branches taken, jumps to their target.
  always_comb begin
    pc4     = pc_q + 32'd4;
    pred_pc = pc4;
    case (imem_instr[31:26])
      OP_BEQ, OP_BNE: pred_pc = pc4 + {{14{imem_instr[15]}}, imem_instr[15:0], 2'b00};
      OP_J, OP_JAL:   pred_pc = {pc4[31:28], imem_instr[25:0], 2'b00};
      default:        pred_pc = pc4;
    endcase
  end

  // Next-state and register updates: halt > miss > stall > fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    do_fetch   = 1'b0;
    do_miss    = 1'b0;
    case (state_q)
      RUN: begin
        if (halt) begin
          state_d    = HALTED;
          if_valid_d = 1'b0;
        end else if (miss) begin
          pc_d       = rpc;
          if_valid_d = 1'b0;
          do_miss    = 1'b1;
        end else if (!stall) begin
          if_instr_d = imem_instr;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pred_pc;
          do_fetch   = 1'b1;
        end
      end
      HALTED: begin
        if_valid_d = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign pc       = pc_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign if_valid = if_valid_q;
  assign halted   = (state_q == HALTED);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_miss_q, perf_miss_d;

  // Event counters for normal fetches and accepted redirects.
  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'd0, do_fetch};
    perf_miss_d  = perf_miss_q + {31'd0, do_miss};
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_miss_q  <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_miss_q  <= perf_miss_d;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_miss  = perf_miss_q;
`else
  logic unused_ok;
  assign unused_ok = do_fetch ^ do_miss;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// traffic compared against a behavioural reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, miss, halt;
  logic [31:0] rpc;
  logic [31:0] imem_instr;
  logic [31:0] pc, if_instr, if_pc;
  logic        if_valid, halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_miss;
`endif

  logic [31:0] mem [0:255];

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_ifpc;
  logic        m_valid, m_halted;
  int unsigned m_fetches, m_misses;

  always #5 clk = ~clk;

  assign imem_instr = mem[pc[9:2]];

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .miss       (miss),
    .rpc        (rpc),
    .halt       (halt),
    .imem_instr (imem_instr),
    .pc         (pc),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_valid   (if_valid),
`ifdef FETCH_PERF_EN
    .perf_fetch (perf_fetch),
    .perf_miss  (perf_miss),
`endif
    .halted     (halted)
  );

  function automatic logic [31:0] predict(input logic [31:0] p, input logic [31:0] w);
    int unsigned op;
    int          off;
    logic [31:0] nxt;
    op  = w >> 26;
    nxt = p + 32'd4;
    if (op == 4 || op == 5) begin
      off = $signed(w[15:0]);
      return nxt + 32'(off * 4);
    end
    if (op == 2 || op == 3)
      return (nxt & 32'hF000_0000) + (w & 32'h03FF_FFFF) * 32'd4;
    return nxt;
  endfunction

  // Apply one cycle of inputs and advance the model; sampling point is #1 after the edge.
  task automatic cycle(input logic r, input logic st, input logic ms,
                       input logic [31:0] rp, input logic hl);
    logic [31:0] w;
    reset = r; stall = st; miss = ms; rpc = rp; halt = hl;
    w = mem[m_pc[9:2]];
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_ifpc = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
      m_fetches = 0; m_misses = 0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (hl) begin
      m_halted = 1'b1; m_valid = 1'b0;
    end else if (ms) begin
      m_pc = rp; m_valid = 1'b0; m_misses++;
    end else if (!st) begin
      m_instr = w; m_ifpc = m_pc; m_valid = 1'b1; m_pc = predict(m_pc, w); m_fetches++;
    end
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic fill_alu();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0020 | (32'(i) << 11);
  endtask

  task automatic test_reset();
    fill_alu();
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0ABC, 1'b1);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_valid); end
    checks++; if (if_instr !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("FAIL reset_ifid got %h/%h exp 0/0", if_instr, if_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
  endtask

  task automatic test_sequential();
    fill_alu();
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1);
    checks++; if (pc !== 32'h4 || if_pc !== 32'h0 || if_valid !== 1'b1) begin errors++; $display("FAIL seq_c1 got pc=%h if_pc=%h v=%b exp 4/0/1", pc, if_pc, if_valid); end
    idle(1);
    checks++; if (pc !== 32'h8 || if_pc !== 32'h4 || if_instr !== mem[1]) begin errors++; $display("FAIL seq_c2 got pc=%h if_pc=%h ins=%h exp 8/4/%h", pc, if_pc, if_instr, mem[1]); end
  endtask

  task automatic test_branch();
    logic [31:0] beq_w;
    fill_alu();
    beq_w = {6'b000100, 5'd1, 5'd2, 16'hFFFC};
    mem[4] = beq_w;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(5);
    checks++; if (pc !== 32'h4 || if_pc !== 32'h10 || if_instr !== beq_w) begin errors++; $display("FAIL beq_pred got pc=%h if_pc=%h ins=%h exp 4/10/%h", pc, if_pc, if_instr, beq_w); end
    cycle(1'b0, 1'b0, 1'b1, 32'h14, 1'b0);
    checks++; if (pc !== 32'h14 || if_valid !== 1'b0 || if_instr !== beq_w || if_pc !== 32'h10) begin errors++; $display("FAIL beq_miss got pc=%h v=%b ins=%h if_pc=%h exp 14/0/%h/10", pc, if_valid, if_instr, if_pc, beq_w); end
    idle(1);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h14 || pc !== 32'h18) begin errors++; $display("FAIL beq_recover got v=%b if_pc=%h pc=%h exp 1/14/18", if_valid, if_pc, pc); end
  endtask

  task automatic test_jump();
    fill_alu();
    mem[8] = {6'b000010, 26'h40};
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(9);
    checks++; if (pc !== 32'h100 || if_pc !== 32'h20) begin errors++; $display("FAIL jump got pc=%h if_pc=%h exp 100/20", pc, if_pc); end
  endtask

  task automatic test_stall_miss();
    fill_alu();
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++; if (pc !== 32'hC || if_pc !== 32'h8 || if_instr !== mem[2] || if_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got pc=%h if_pc=%h ins=%h v=%b exp c/8/%h/1", pc, if_pc, if_instr, if_valid, mem[2]); end
    end
    cycle(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
    checks++; if (pc !== 32'h200 || if_valid !== 1'b0 || if_pc !== 32'h8) begin errors++; $display("FAIL stall_miss got pc=%h v=%b if_pc=%h exp 200/0/8", pc, if_valid, if_pc); end
  endtask

  task automatic test_halt();
    fill_alu();
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
    checks++; if (halted !== 1'b1 || pc !== 32'h8 || if_valid !== 1'b0) begin errors++; $display("FAIL halt got h=%b pc=%h v=%b exp 1/8/0", halted, pc, if_valid); end
    cycle(1'b0, 1'b0, 1'b1, 32'h400, 1'b0);
    idle(1);
    checks++; if (halted !== 1'b1 || pc !== 32'h8 || if_valid !== 1'b0 || if_pc !== 32'h4) begin errors++; $display("FAIL halt_hold got h=%b pc=%h v=%b if_pc=%h exp 1/8/0/4", halted, pc, if_valid, if_pc); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (halted !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL halt_reset got h=%b pc=%h exp 0/0", halted, pc); end
  endtask

  task automatic test_random();
    logic r, st, ms, hl;
    logic [31:0] rp;
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 5))
        0: mem[i] = {6'b000100, 10'($urandom), 16'($urandom)};
        1: mem[i] = {6'b000101, 10'($urandom), 16'($urandom)};
        2: mem[i] = {6'b000010, 26'($urandom)};
        3: mem[i] = {6'b000011, 26'($urandom)};
        4: mem[i] = {6'b100011, 26'($urandom)};
        default: mem[i] = {6'b000000, 26'($urandom)};
      endcase
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 25);
      ms = ($urandom_range(0, 99) < 15);
      hl = ($urandom_range(0, 99) < 2);
      rp = $urandom;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      cycle(r, st, ms, rp, hl);
      checks++;
      if (pc !== m_pc || if_instr !== m_instr || if_pc !== m_ifpc || if_valid !== m_valid || halted !== m_halted) begin
        errors++;
        $display("FAIL rand_%0d got pc=%h ins=%h ifpc=%h v=%b h=%b exp %h %h %h %b %b",
                 n, pc, if_instr, if_pc, if_valid, halted, m_pc, m_instr, m_ifpc, m_valid, m_halted);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_fetch !== 32'(m_fetches) || perf_miss !== 32'(m_misses)) begin
        errors++;
        $display("FAIL rand_perf_%0d got %0d/%0d exp %0d/%0d", n, perf_fetch, perf_miss, m_fetches, m_misses);
      end
`endif
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    fill_alu();
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(2);
    cycle(1'b0, 1'b1, 1'b1, 32'h80, 1'b0);
    checks++; if (perf_fetch !== 32'd5 || perf_miss !== 32'd2) begin errors++; $display("FAIL perf_count got %0d/%0d exp 5/2", perf_fetch, perf_miss); end
    cycle(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    checks++; if (perf_fetch !== 32'd0 || perf_miss !== 32'd0) begin errors++; $display("FAIL perf_reset got %0d/%0d exp 0/0", perf_fetch, perf_miss); end
  endtask
`endif

  initial begin
    reset = 1'b1; stall = 1'b0; miss = 1'b0; halt = 1'b0; rpc = 32'h0;
    m_pc = 32'h0; m_instr = 32'h0; m_ifpc = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
    m_fetches = 0; m_misses = 0;
    fill_alu();
    #2;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall_miss();
    test_halt();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
